branch_resolve_unit: RTL and testbench
======================================

BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 Parameter DEPTH, default 4, in-flight prediction queue entries; power of two, >= 2.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 fetch_valid  input  1  fetch presents a predicted branch.
REQ-005 fetch_ready  output  1  queue accepts an entry this cycle.
REQ-006 fetch_pc  input  64  PC of the fetched branch.
REQ-007 fetch_pred_taken  input  1  predictor direction.
REQ-008 fetch_pred_target  input  64  predictor target.
REQ-009 ex_valid  input  1  execute stage resolves the oldest in-flight branch.
REQ-010 ex_pc  input  64  PC of the resolving branch.
REQ-011 ex_taken  input  1  actual direction.
REQ-012 ex_target  input  64  actual taken target.
REQ-013 branch_resolved  output  1  predictor update strobe.
REQ-014 actual_taken  output  1  resolved direction to predictor.
REQ-015 branch_pc  output  64  resolved branch PC to predictor.
REQ-016 branch_target_resolved  output  64  resolved target to predictor.
REQ-017 flush  output  1  one-cycle pipeline flush pulse.
REQ-018 redirect_pc  output  64  fetch restart address, valid while flush=1.
REQ-019 tag_error  output  1  sticky protocol-error flag.
REQ-020 resolved_count, mispredict_count  output  32 each  event counters.

Function
REQ-021 Queue is in-order FIFO of {pc, pred_taken, pred_target}; enqueue when fetch_valid && fetch_ready.
REQ-022 fetch_ready = (count != DEPTH) && !flush, combinational from registered state.
REQ-023 Resolve when ex_valid && count != 0: head popped at that edge; head compared with ex_* inputs.
REQ-024 Mispredict = (pred_taken != ex_taken) || (ex_taken && pred_target != ex_target).
REQ-025 All outputs registered: resolve in cycle N -> branch_resolved/flush/redirect visible in cycle N+1, for exactly one cycle.
REQ-026 branch_resolved=1 for every resolve; actual_taken, branch_pc, branch_target_resolved = ex_taken, ex_pc, ex_target.
REQ-027 On mispredict: flush=1; redirect_pc = ex_taken ? ex_target : ex_pc + 4 (64-bit, wraps modulo 2^64).
REQ-028 On mispredict: whole queue emptied at edge N (younger entries wrong-path); same-cycle enqueue dropped.
REQ-029 Simultaneous enqueue and non-mispredicting resolve: count unchanged; both pointers advance mod DEPTH.
REQ-030 Full: fetch_ready=0; a resolve in the same cycle frees the slot for the next cycle only.
REQ-031 ex_valid with count==0: ignored (no update strobe, no counter change), tag_error set.
REQ-032 ex_pc != head pc: resolve still processed per REQ-023..028, tag_error set.
REQ-033 resolved_count +1 per resolve, mispredict_count +1 per mispredict; both wrap at 2^32.
REQ-034 Non-strobe cycles: branch_resolved=0, flush=0; data outputs hold last values.

Reset
REQ-035 reset=1 at an edge: count, pointers, counters, tag_error, all outputs cleared to 0; inputs ignored that cycle.
REQ-036 Reset mid-operation discards all in-flight entries; no flush or update pulse generated.
REQ-037 fetch_ready=1 in first cycle after reset release.

Structure
REQ-038 Shared package: DEPTH default, 64-bit address width, PC increment constant 4, queue-entry struct.
REQ-039 One sub-module branch_pred_fifo (storage, pointers, count, synchronous clear); compare/counter logic in top.

Verification
REQ-040 Enqueue pc=0x100 pred NT; resolve NT pc=0x100 -> next cycle branch_resolved=1, flush=0, resolved_count=1.
REQ-041 Enqueue pc=0x200 pred T tgt 0x300; resolve NT -> flush=1, redirect_pc=0x204, mispredict_count=1, queue empty.
REQ-042 Pred T tgt 0x300, actual T tgt 0x400 -> flush=1, redirect_pc=0x400.
REQ-043 Fill 4 entries -> fetch_ready=0; enqueue+resolve same cycle -> entry dropped, count 3, ready=1 next cycle.
REQ-044 ex_valid on empty queue, then ex_pc=0x500 vs head 0x100 -> tag_error=1 and stays set until reset.
REQ-045 Reset asserted with 3 entries queued -> count 0, counters 0, no flush/branch_resolved pulse.

Source files
------------

// File: rtl/branch_resolve_unit_pkg.sv
// Shared types and constants for the branch resolve unit: address width,
// PC increment for fall-through redirects, and the in-flight prediction entry.
package branch_resolve_unit_pkg;

  localparam int DEPTH_DEFAULT = 4;
  localparam int ADDR_W        = 64;

  localparam logic [ADDR_W-1:0] PC_INC = 64'd4;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic              pred_taken;
    logic [ADDR_W-1:0] pred_target;
  } pred_entry_t;

endpackage

// File: rtl/branch_pred_fifo.sv
// In-order storage for in-flight branch predictions. Clear empties the queue
// at the edge and wins over any push or pop presented in the same cycle.
module branch_pred_fifo
  import branch_resolve_unit_pkg::*;
#(
  parameter  int DEPTH = DEPTH_DEFAULT,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          push,
  input  pred_entry_t   push_data,
  input  logic          pop,
  output pred_entry_t   head,
  output logic [CW-1:0] count
);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  pred_entry_t   mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  // Guard against over/underflow even though the top already gates both.
  assign push_ok = push && (count != FULL_CNT);
  assign pop_ok  = pop && (count != '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset && !clear && push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Matches execute-stage branch outcomes against queued predictions, strobes
// predictor updates and raises a one-cycle flush with redirect on mispredicts.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_valid,
  output logic              fetch_ready,
  input  logic [ADDR_W-1:0] fetch_pc,
  input  logic              fetch_pred_taken,
  input  logic [ADDR_W-1:0] fetch_pred_target,
  input  logic              ex_valid,
  input  logic [ADDR_W-1:0] ex_pc,
  input  logic              ex_taken,
  input  logic [ADDR_W-1:0] ex_target,
  output logic              branch_resolved,
  output logic              actual_taken,
  output logic [ADDR_W-1:0] branch_pc,
  output logic [ADDR_W-1:0] branch_target_resolved,
  output logic              flush,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              tag_error,
  output logic [31:0]       resolved_count,
  output logic [31:0]       mispredict_count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  pred_entry_t   head;
  pred_entry_t   new_entry;
  logic [CW-1:0] count;
  logic          resolve;
  logic          mispredict;
  logic          enqueue;
  logic          proto_err;

  // Handshake: an entry transfers on a rising edge where fetch_valid and
  // fetch_ready are both high; ready is low while full or while flushing.
  assign fetch_ready = (count != FULL_CNT) && !flush;

  assign resolve    = ex_valid && (count != '0);
  assign mispredict = resolve &&
                      ((head.pred_taken != ex_taken) ||
                       (ex_taken && (head.pred_target != ex_target)));
  // Anything fetched alongside a mispredict is on the wrong path.
  assign enqueue    = fetch_valid && fetch_ready && !mispredict;
  assign proto_err  = (ex_valid && (count == '0)) ||
                      (resolve && (ex_pc != head.pc));

  assign new_entry = '{pc: fetch_pc, pred_taken: fetch_pred_taken,
                       pred_target: fetch_pred_target};

  branch_pred_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (mispredict),
    .push      (enqueue),
    .push_data (new_entry),
    .pop       (resolve),
    .head      (head),
    .count     (count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      branch_resolved        <= 1'b0;
      actual_taken           <= 1'b0;
      branch_pc              <= '0;
      branch_target_resolved <= '0;
      flush                  <= 1'b0;
      redirect_pc            <= '0;
      tag_error              <= 1'b0;
      resolved_count         <= '0;
      mispredict_count       <= '0;
    end else begin
      branch_resolved <= resolve;
      flush           <= mispredict;
      if (resolve) begin
        actual_taken           <= ex_taken;
        branch_pc              <= ex_pc;
        branch_target_resolved <= ex_target;
        resolved_count         <= resolved_count + 32'd1;
      end
      if (mispredict) begin
        redirect_pc      <= ex_taken ? ex_target : (ex_pc + PC_INC);
        mispredict_count <= mispredict_count + 32'd1;
      end
      if (proto_err) begin
        tag_error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: hand-computed expectations for
// resolve, mispredict, full-queue, protocol-error and reset behaviour.
module tb_branch_resolve_unit;

  logic        clk;
  logic        reset;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [63:0] fetch_pc;
  logic        fetch_pred_taken;
  logic [63:0] fetch_pred_target;
  logic        ex_valid;
  logic [63:0] ex_pc;
  logic        ex_taken;
  logic [63:0] ex_target;
  logic        branch_resolved;
  logic        actual_taken;
  logic [63:0] branch_pc;
  logic [63:0] branch_target_resolved;
  logic        flush;
  logic [63:0] redirect_pc;
  logic        tag_error;
  logic [31:0] resolved_count;
  logic [31:0] mispredict_count;

  int n_cmp;
  int n_err;
  logic [63:0] exp_q[$];
  logic [63:0] exp_pc;

  branch_resolve_unit #(.DEPTH(4)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .fetch_valid            (fetch_valid),
    .fetch_ready            (fetch_ready),
    .fetch_pc               (fetch_pc),
    .fetch_pred_taken       (fetch_pred_taken),
    .fetch_pred_target      (fetch_pred_target),
    .ex_valid               (ex_valid),
    .ex_pc                  (ex_pc),
    .ex_taken               (ex_taken),
    .ex_target              (ex_target),
    .branch_resolved        (branch_resolved),
    .actual_taken           (actual_taken),
    .branch_pc              (branch_pc),
    .branch_target_resolved (branch_target_resolved),
    .flush                  (flush),
    .redirect_pc            (redirect_pc),
    .tag_error              (tag_error),
    .resolved_count         (resolved_count),
    .mispredict_count       (mispredict_count)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fetch(input logic [63:0] pc, input logic pt, input logic [63:0] tgt);
    fetch_valid       = 1'b1;
    fetch_pc          = pc;
    fetch_pred_taken  = pt;
    fetch_pred_target = tgt;
  endtask

  task automatic set_ex(input logic [63:0] pc, input logic tk, input logic [63:0] tgt);
    ex_valid  = 1'b1;
    ex_pc     = pc;
    ex_taken  = tk;
    ex_target = tgt;
  endtask

  task automatic enq(input logic [63:0] pc, input logic pt, input logic [63:0] tgt);
    set_fetch(pc, pt, tgt);
    step();
    fetch_valid = 1'b0;
  endtask

  task automatic res(input logic [63:0] pc, input logic tk, input logic [63:0] tgt);
    set_ex(pc, tk, tgt);
    step();
    ex_valid = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    fetch_valid = 1'b0; fetch_pc = '0; fetch_pred_taken = 1'b0; fetch_pred_target = '0;
    ex_valid = 1'b0; ex_pc = '0; ex_taken = 1'b0; ex_target = '0;
    step();
    step();
    reset = 1'b0;

    // Reset state
    check("rst_ready", fetch_ready, 1);
    check("rst_resolved", branch_resolved, 0);
    check("rst_flush", flush, 0);
    check("rst_rcount", resolved_count, 0);
    check("rst_mcount", mispredict_count, 0);
    check("rst_tag", tag_error, 0);

    // Correct not-taken prediction
    enq(64'h100, 1'b0, 64'h0);
    res(64'h100, 1'b0, 64'h0);
    check("nt_resolved", branch_resolved, 1);
    check("nt_flush", flush, 0);
    check("nt_rcount", resolved_count, 1);
    check("nt_pc", branch_pc, 64'h100);
    check("nt_taken", actual_taken, 0);
    step();
    check("nt_pulse_end", branch_resolved, 0);
    check("nt_pc_hold", branch_pc, 64'h100);

    // Predicted taken, actually not taken; younger entry and same-cycle fetch discarded
    enq(64'h200, 1'b1, 64'h300);
    enq(64'h210, 1'b0, 64'h0);
    set_fetch(64'h220, 1'b0, 64'h0);
    res(64'h200, 1'b0, 64'h0);
    fetch_valid = 1'b0;
    check("dir_flush", flush, 1);
    check("dir_redirect", redirect_pc, 64'h204);
    check("dir_mcount", mispredict_count, 1);
    check("dir_rcount", resolved_count, 2);
    check("dir_ready_in_flush", fetch_ready, 0);
    step();
    check("dir_flush_end", flush, 0);
    check("dir_ready_after", fetch_ready, 1);

    // Direction right, target wrong
    enq(64'h280, 1'b1, 64'h300);
    res(64'h280, 1'b1, 64'h400);
    check("tgt_flush", flush, 1);
    check("tgt_redirect", redirect_pc, 64'h400);
    check("tgt_target", branch_target_resolved, 64'h400);
    check("tgt_taken", actual_taken, 1);
    check("tgt_mcount", mispredict_count, 2);
    step();

    // Fill: ready drops only at the fourth entry, which also shows the flush emptied the queue
    for (int i = 0; i < 4; i++) begin
      exp_pc = 64'h1000 + 64'(i) * 64'h10;
      enq(exp_pc, 1'b0, 64'h0);
      exp_q.push_back(exp_pc);
      if (i == 2) check("fill_ready_3", fetch_ready, 1);
    end
    check("full_ready", fetch_ready, 0);
    // Enqueue while full is dropped even though a resolve frees a slot
    set_fetch(64'h1040, 1'b0, 64'h0);
    res(64'h1000, 1'b0, 64'h0);
    fetch_valid = 1'b0;
    exp_pc = exp_q.pop_front();
    check("full_res_pc", branch_pc, exp_pc);
    check("full_res_flush", flush, 0);
    check("full_ready_next", fetch_ready, 1);
    for (int i = 0; i < 3; i++) begin
      exp_pc = exp_q.pop_front();
      res(exp_pc, 1'b0, 64'h0);
      check("drain_pc", branch_pc, exp_pc);
      check("drain_resolved", branch_resolved, 1);
    end
    check("drain_rcount", resolved_count, 7);

    // Resolve against empty queue: ignored, protocol error
    res(64'h600, 1'b0, 64'h0);
    check("empty_resolved", branch_resolved, 0);
    check("empty_rcount", resolved_count, 7);
    check("empty_tag", tag_error, 1);

    // Fall-through redirect wraps modulo 2^64
    enq(64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 64'h10);
    res(64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 64'h0);
    check("wrap_flush", flush, 1);
    check("wrap_redirect", redirect_pc, 64'h0);
    check("wrap_mcount", mispredict_count, 3);
    check("tag_sticky", tag_error, 1);
    step();

    // Reset with entries in flight; a fetch during reset is ignored
    enq(64'h700, 1'b0, 64'h0);
    enq(64'h710, 1'b0, 64'h0);
    enq(64'h720, 1'b0, 64'h0);
    reset = 1'b1;
    set_fetch(64'h800, 1'b0, 64'h0);
    step();
    fetch_valid = 1'b0;
    reset = 1'b0;
    check("mrst_ready", fetch_ready, 1);
    check("mrst_rcount", resolved_count, 0);
    check("mrst_mcount", mispredict_count, 0);
    check("mrst_tag", tag_error, 0);
    check("mrst_flush", flush, 0);
    check("mrst_resolved", branch_resolved, 0);
    step();
    check("mrst_flush_after", flush, 0);
    check("mrst_resolved_after", branch_resolved, 0);
    res(64'h700, 1'b0, 64'h0);
    check("mrst_empty_resolved", branch_resolved, 0);
    check("mrst_empty_tag", tag_error, 1);

    // Tag mismatch: resolve still processed against the head entry
    reset = 1'b1;
    step();
    reset = 1'b0;
    enq(64'h100, 1'b0, 64'h0);
    res(64'h500, 1'b0, 64'h0);
    check("tagm_resolved", branch_resolved, 1);
    check("tagm_pc", branch_pc, 64'h500);
    check("tagm_flush", flush, 0);
    check("tagm_rcount", resolved_count, 1);
    check("tagm_tag", tag_error, 1);
    step();
    check("tagm_tag_sticky", tag_error, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
